// File: rtl/sha256_stream_core.sv
// ============================================================================
// Module      : sha256_stream_core
// Description : Streaming SHA-256/SHA-224 engine over pre-padded 32-bit words
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_stream_core #(
   parameter int SUPPORT_224 = 1,
   parameter int BLKCNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_data,
   input  logic                in_first,
   input  logic                in_last,
   input  logic                mode_224,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [255:0]        out_digest,
   output logic                busy,
   output logic [BLKCNT_W-1:0] blk_cnt
);

   typedef enum logic [1:0] {S_LOAD = 2'd0, S_ROUND = 2'd1, S_UPDATE = 2'd2, S_OUT = 2'd3} state_t;

   localparam logic [31:0] c_k [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] c_iv256 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] c_iv224 =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   state_t              r_state, w_state_nxt;
   logic                r_rdy_en, r_open, r_mode224, r_last;
   logic [3:0]          r_wcnt;
   logic [5:0]          r_rcnt;
   logic [31:0]         r_win [16];
   logic [31:0]         r_h   [8];
   logic [31:0]         r_v   [8];
   logic [255:0]        r_digest;
   logic [BLKCNT_W-1:0] r_blk_cnt;

   logic                w_xfer, w_newmsg, w_mode_sel;
   logic [255:0]        w_iv_sel;
   logic [31:0]         w_t1, w_t2, w_wnext;
   logic [31:0]         w_hsum [8];

   assign in_ready   = (r_state == S_LOAD) && r_rdy_en;
   assign out_valid  = (r_state == S_OUT);
   assign out_digest = r_digest;
   assign busy       = r_open;
   assign blk_cnt    = r_blk_cnt;

   assign w_xfer     = in_valid && in_ready;
   assign w_newmsg   = w_xfer && (r_wcnt == 4'd0) && (in_first || !r_open);
   assign w_mode_sel = (SUPPORT_224 != 0) && mode_224;
   assign w_iv_sel   = w_mode_sel ? c_iv224 : c_iv256;

   // One compression round on a..h, plus the next schedule word from the window
   assign w_t1 = r_v[7] + (rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25))
               + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + c_k[r_rcnt] + r_win[0];
   assign w_t2 = (rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22))
               + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
   assign w_wnext = (rotr(r_win[14], 17) ^ rotr(r_win[14], 19) ^ (r_win[14] >> 10)) + r_win[9]
                  + (rotr(r_win[1], 7) ^ rotr(r_win[1], 18) ^ (r_win[1] >> 3)) + r_win[0];

   always_comb begin
      for (int i = 0; i < 8; i++) w_hsum[i] = r_h[i] + r_v[i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_LOAD;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_LOAD:   if (w_xfer && (r_wcnt == 4'd15)) w_state_nxt = S_ROUND;
         S_ROUND:  if (r_rcnt == 6'd63) w_state_nxt = S_UPDATE;
         S_UPDATE: w_state_nxt = r_last ? S_OUT : S_LOAD;
         S_OUT:    if (out_ready) w_state_nxt = S_LOAD;
         default:  w_state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdy_en  <= 1'b0;
         r_open    <= 1'b0;
         r_mode224 <= 1'b0;
         r_last    <= 1'b0;
         r_wcnt    <= '0;
         r_rcnt    <= '0;
         r_digest  <= '0;
         r_blk_cnt <= '0;
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
         for (int i = 0; i < 8; i++) begin
            r_h[i] <= '0;
            r_v[i] <= '0;
         end
      end else begin
         r_rdy_en <= 1'b1;
         case (r_state)
            S_LOAD: if (w_xfer) begin
               r_win[r_wcnt] <= in_data;
               r_wcnt        <= r_wcnt + 4'd1;
               if (w_newmsg) begin
                  for (int i = 0; i < 8; i++) r_h[i] <= w_iv_sel[255-32*i -: 32];
                  r_blk_cnt <= '0;
                  r_open    <= 1'b1;
                  r_mode224 <= w_mode_sel;
               end
               if (r_wcnt == 4'd15) begin
                  r_last <= in_last;
                  for (int i = 0; i < 8; i++) r_v[i] <= r_h[i];
               end
            end
            S_ROUND: begin
               r_rcnt <= r_rcnt + 6'd1;
               for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
               r_win[15] <= w_wnext;
               r_v[0] <= w_t1 + w_t2;
               r_v[1] <= r_v[0];
               r_v[2] <= r_v[1];
               r_v[3] <= r_v[2];
               r_v[4] <= r_v[3] + w_t1;
               r_v[5] <= r_v[4];
               r_v[6] <= r_v[5];
               r_v[7] <= r_v[6];
            end
            S_UPDATE: begin
               for (int i = 0; i < 8; i++) r_h[i] <= w_hsum[i];
               if (!(&r_blk_cnt)) r_blk_cnt <= r_blk_cnt + 1'b1;
               if (r_last)
                  r_digest <= {w_hsum[0], w_hsum[1], w_hsum[2], w_hsum[3], w_hsum[4],
                               w_hsum[5], w_hsum[6], r_mode224 ? 32'h0 : w_hsum[7]};
            end
            S_OUT: if (out_ready) r_open <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sha256_stream_core.sv
// ============================================================================
// Module      : tb_sha256_stream_core
// Description : Directed known-answer bench for sha256_stream_core
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_stream_core;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_data = '0;
   logic         in_first = 1'b0;
   logic         in_last = 1'b0;
   logic         mode_224 = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [255:0] out_digest;
   logic         busy;
   logic [15:0]  blk_cnt;

   int checks = 0;
   int errors = 0;
   logic [31:0] blk [16];

   localparam logic [255:0] c_abc256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] c_abc224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
   localparam logic [255:0] c_empty  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] c_two    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   sha256_stream_core #(.SUPPORT_224(1), .BLKCNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_first(in_first), .in_last(in_last), .mode_224(mode_224),
      .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest),
      .busy(busy), .blk_cnt(blk_cnt)
   );

   always #5 clk = ~clk;

   task automatic load_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   task automatic send_block(input bit first, input bit last, input bit mode, input bit rnd, output bit ok);
      int i;
      int guard;
      i = 0; guard = 0; ok = 1'b1;
      while (i < 16) begin
         @(negedge clk);
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = blk[i];
         in_first = first;
         in_last  = last;
         mode_224 = mode;
         if (in_valid && in_ready) i++;
         guard++;
         if (guard > 400) begin
            ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_out(output int cyc, output bit saw_ready);
      cyc = 0; saw_ready = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
         cyc++;
         if (in_ready) saw_ready = 1'b1;
         if (out_valid) break;
      end
      if (!out_valid) cyc = -1;
   endtask

   task automatic wait_ready(output int cyc, output bit saw_valid);
      cyc = 0; saw_valid = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
         cyc++;
         if (out_valid) saw_valid = 1'b1;
         if (in_ready) break;
      end
      if (!in_ready) cyc = -1;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {out_valid, busy}); end
      checks++; if (out_digest !== 256'h0) begin errors++; $display("FAIL reset_digest got=%h exp=0", out_digest); end
      checks++; if (blk_cnt !== 16'h0) begin errors++; $display("FAIL reset_blk_cnt got=%0d exp=0", blk_cnt); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_first_cycle_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic run_single(input string name, input bit mode, input logic [255:0] exp);
      bit ok, saw;
      int cyc;
      send_block(1'b1, 1'b1, mode, 1'b0, ok);
      wait_out(cyc, saw);
      checks++; if (!ok || cyc != 66) begin errors++; $display("FAIL %s_latency got=%0d exp=66", name, cyc); end
      checks++; if (out_digest !== exp) begin errors++; $display("FAIL %s_digest got=%h exp=%h", name, out_digest, exp); end
      checks++; if (blk_cnt !== 16'd1 || busy !== 1'b1) begin errors++; $display("FAIL %s_status got cnt=%0d busy=%b exp cnt=1 busy=1", name, blk_cnt, busy); end
      checks++; if (saw) begin errors++; $display("FAIL %s_ready_in_rounds got=1 exp=0", name); end
      handshake();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_close got valid=%b busy=%b exp 0 0", name, out_valid, busy); end
      checks++; if (out_digest !== exp) begin errors++; $display("FAIL %s_digest_hold got=%h exp=%h", name, out_digest, exp); end
   endtask

   task automatic test_abc();
      load_abc();
      run_single("abc256", 1'b0, c_abc256);
   endtask

   task automatic test_abc224();
      load_abc();
      run_single("abc224", 1'b1, c_abc224);
   endtask

   task automatic test_empty();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0] = 32'h80000000;
      run_single("empty", 1'b0, c_empty);
   endtask

   task automatic test_two_block();
      bit ok1, ok2, saw;
      int cyc;
      logic [31:0] msg [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                                32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                                32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
      for (int i = 0; i < 14; i++) blk[i] = msg[i];
      blk[14] = 32'h80000000;
      blk[15] = 32'h0;
      send_block(1'b1, 1'b0, 1'b0, 1'b1, ok1);
      wait_ready(cyc, saw);
      checks++; if (!ok1 || cyc != 66 || saw) begin errors++; $display("FAIL two_block_ready_gap got=%0d valid_seen=%b exp=66 0", cyc, saw); end
      for (int i = 0; i < 15; i++) blk[i] = 32'h0;
      blk[15] = 32'h000001c0;
      send_block(1'b0, 1'b1, 1'b0, 1'b1, ok2);
      wait_out(cyc, saw);
      checks++; if (!ok2 || cyc != 66 || saw) begin errors++; $display("FAIL two_block_latency got=%0d ready_seen=%b exp=66 0", cyc, saw); end
      checks++; if (out_digest !== c_two) begin errors++; $display("FAIL two_block_digest got=%h exp=%h", out_digest, c_two); end
      checks++; if (blk_cnt !== 16'd2) begin errors++; $display("FAIL two_block_blk_cnt got=%0d exp=2", blk_cnt); end
      handshake();
   endtask

   task automatic test_backpressure();
      bit ok, saw;
      int cyc;
      load_abc();
      send_block(1'b1, 1'b1, 1'b0, 1'b0, ok);
      wait_out(cyc, saw);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_digest !== c_abc256) begin
            errors++;
            $display("FAIL backpressure_hold cyc=%0d got valid=%b ready=%b dig=%h exp 1 0 %h", k, out_valid, in_ready, out_digest, c_abc256);
         end
      end
      handshake();
      run_single("after_bp", 1'b0, c_abc256);
   endtask

   task automatic test_reset_mid();
      bit ok;
      load_abc();
      send_block(1'b1, 1'b1, 1'b0, 1'b0, ok);
      repeat (31) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      checks++; if ({out_valid, busy, in_ready} !== 3'b000 || blk_cnt !== 16'h0 || out_digest !== 256'h0) begin
         errors++; $display("FAIL midreset_outputs got v=%b b=%b r=%b cnt=%0d dig=%h exp all 0", out_valid, busy, in_ready, blk_cnt, out_digest);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready_early got=%b exp=0", in_ready); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_ready got r=%b v=%b exp 1 0", in_ready, out_valid); end
      load_abc();
      run_single("after_reset", 1'b0, c_abc256);
   endtask

   task automatic test_abort();
      bit ok1, ok2, saw;
      int cyc;
      for (int i = 0; i < 16; i++) blk[i] = 32'h01010101 * (i + 3);
      send_block(1'b1, 1'b0, 1'b0, 1'b0, ok1);
      wait_ready(cyc, saw);
      checks++; if (!ok1 || cyc != 66 || saw) begin errors++; $display("FAIL abort_no_digest got=%0d valid_seen=%b exp=66 0", cyc, saw); end
      checks++; if (blk_cnt !== 16'd1 || busy !== 1'b1) begin errors++; $display("FAIL abort_open got cnt=%0d busy=%b exp 1 1", blk_cnt, busy); end
      load_abc();
      send_block(1'b1, 1'b1, 1'b0, 1'b0, ok2);
      wait_out(cyc, saw);
      checks++; if (!ok2 || cyc != 66) begin errors++; $display("FAIL abort_latency got=%0d exp=66", cyc); end
      checks++; if (out_digest !== c_abc256) begin errors++; $display("FAIL abort_digest got=%h exp=%h", out_digest, c_abc256); end
      checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL abort_blk_cnt got=%0d exp=1", blk_cnt); end
      handshake();
   endtask

   initial begin
      test_reset();
      test_abc();
      test_abc224();
      test_empty();
      test_two_block();
      test_backpressure();
      test_reset_mid();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
- Next-generation SHA-256 engine that replaces the fixed 24-bit, single-block wrapper datapath.
- Accepts pre-padded messages of any length as a stream of 32-bit words, 16 words per 512-bit block, over a valid/ready handshake.
- Chains intermediate hash state across blocks and optionally runs SHA-224 (different IV, truncated digest).
- Presents the final digest on a valid/ready output; a register-map front end or DMA sits on both sides.

Parameters:
- SUPPORT_224, 1, 1 = mode_224 honoured; 0 = mode_224 ignored, always SHA-256.
- BLKCNT_W, 16, width of the blk_cnt status counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  core can accept a word
- in_data  in  32  message word, big-endian word order within the block
- in_first  in  1  sampled on word 0 of a block: this block starts a new message
- in_last  in  1  sampled on word 15 of a block: this block ends the message
- mode_224  in  1  sampled with the first block of a message: 1 = SHA-224
- out_valid  out  1  digest valid
- out_ready  in  1  digest consumer ready
- out_digest  out  256  H0..H7, H0 in [255:224]; in SHA-224 mode [31:0]=0
- busy  out  1  message open or digest pending
- blk_cnt  out  BLKCNT_W  blocks completed in the current message, saturating

Behaviour:
- Reset (async assert, sync release) gives in_ready=0 for one cycle, then 1.
- All other outputs reset to 0: out_valid, out_digest, busy, blk_cnt.
- Hash state, word counter and round counter clear; state goes to LOAD; no message is open.
- State LOAD:
  - in_ready=1.
  - A word transfers when in_valid&&in_ready; it is written to window[wcnt] and wcnt increments (4-bit).
  - At word 0: if in_first=1 or no message is open, H is loaded with the IV for the selected mode, blk_cnt clears, the message opens and the mode latches.
  - A word transfer is required to latch anything; in_first on words 1..15 and in_last on words 0..14 are ignored.
  - On the transfer of word 15, in_last latches, wcnt wraps to 0 and the state goes to ROUND.
- State ROUND:
  - 64 cycles, t=0..63; in_ready=0.
  - Working vars a..h load from H in the transfer cycle of word 15.
  - Each cycle uses K[t] and W[t]=window[0]; the window shifts down one entry.
  - window[15] receives sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], computed from the 16-entry window.
  - All arithmetic is mod 2^32.
  - After t=63 the state goes to UPDATE.
- State UPDATE:
  - One cycle: H[i] <= H[i] + var[i]; blk_cnt increments, saturating at all-ones.
  - If the latched last flag is 1, go to OUT; otherwise go to LOAD.
- Latency:
  - Word 15 accepted at edge N; rounds fill cycles N+1..N+64; UPDATE is N+65.
  - Non-last block: in_ready=1 from N+66.
  - Last block: out_valid=1 from N+66.
- State OUT:
  - out_valid=1 and out_digest is stable while out_ready=0.
  - On out_valid&&out_ready the message closes, out_valid falls next cycle and the state goes to LOAD.
  - out_digest holds its last value until the next digest.
- busy:
  - 1 from the accept of word 0 of a first block until the digest handshake completes.
  - 0 in LOAD with no message open.
- in_first=1 on word 0 while a message is open aborts the old message: IV reloads and blk_cnt restarts; no digest is emitted for the old message.
- Reset asserted mid-ROUND or mid-OUT: immediate return to the reset values; no partial digest is ever presented.
- SUPPORT_224=0: mode_224 has no effect; out_digest[31:0] carries H7.
- IVs:
  - SHA-256: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - SHA-224: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.

Test Plan:
- "abc" as one padded block (61626380, 0 x14, 00000018), first=last=1, mode_224=0 -> out_digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; out_valid exactly 66 cycles after word 15; blk_cnt=1.
- Same block with mode_224=1 -> digest 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, with [31:0]=0.
- Empty message (80000000, then 15 zero words) -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 448-bit "abcdbcde...nopq" as 2 blocks, in_valid toggled randomly -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; blk_cnt=2; in_ready=0 throughout rounds.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_digest stable, in_ready=0. Then a new "abc" message immediately after the handshake -> correct digest with no state carried over.
- Reset pulse at round t=30 of block 1 -> all outputs 0 and in_ready=1 the cycle after reset release + 1. A following "abc" -> correct digest.
- Abort: 1 block of message A with in_last=0, then "abc" with in_first=1 -> only the "abc" digest is emitted; blk_cnt=1.
